if_id_buffer: RTL and testbench

- Decoupling pipeline stage between the fetch stage (PC, adder, instruction memory) and decode.
- Captures each fetched {pc, instruction} pair into a 2-entry FIFO with valid/ready handshakes on both sides, so decode stalls never drop or duplicate fetched instructions.
- Supports flush on a taken branch (pc_src) and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/if_id_buffer_pkg.sv | 17 +
 rtl/if_id_buffer_entry_reg.sv | 24 ++
 rtl/if_id_buffer.sv | 103 ++++++++++
 tb/tb_if_id_buffer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared types and constants for the IF/ID decoupling buffer.
//   WORD        : PC width
//   INSTR_LEN   : instruction word width
//   IFID_DEPTH  : buffer entries (fixed at 2)
//   IFID_CNT_W  : default stall-cycle counter width
//   ifid_entry_t: one buffered {pc, instr} pair
package if_id_buffer_pkg;
  localparam int WORD       = 32;
  localparam int INSTR_LEN  = 32;
  localparam int IFID_DEPTH = 2;
  localparam int IFID_CNT_W = 32;

  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [INSTR_LEN-1:0] instr;
  } ifid_entry_t;
endpackage

// File: rtl/if_id_buffer_entry_reg.sv
// ifid_entry_reg: one {pc, instr} storage slot of the IF/ID buffer.
//   clk   : pipeline clock
//   reset : async active-high reset, clears the slot
//   we_i  : load d_i on the next rising edge
//   d_i   : entry to store
//   q_o   : stored entry
module ifid_entry_reg
  import if_id_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  ifid_entry_t d_i,
  output ifid_entry_t q_o
);
  ifid_entry_t ent_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ent_q <= '0;
    else if (we_i) ent_q <= d_i;
  end

  assign q_o = ent_q;
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: 2-entry FIFO between fetch and decode with valid/ready on
// both sides, flush on taken branch and a saturating stall-cycle counter.
//   clk, reset                         : clock, async active-high reset
//   fetch_valid/fetch_pc/fetch_instr   : fetch-side request
//   fetch_ready                        : buffer can accept a push
//   flush                              : drop all entries and same-cycle push
//   dec_valid/dec_pc/dec_instr         : head entry toward decode (0 when empty)
//   dec_ready                          : decode consumes the head entry
//   stall_cycles                       : cycles fetch was held off (saturating)
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = IFID_DEPTH,
  parameter int CNT_W = IFID_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [WORD-1:0]      fetch_pc,
  input  logic [INSTR_LEN-1:0] fetch_instr,
  output logic                 fetch_ready,
  input  logic                 flush,
  output logic                 dec_valid,
  output logic [WORD-1:0]      dec_pc,
  output logic [INSTR_LEN-1:0] dec_instr,
  input  logic                 dec_ready,
  output logic [CNT_W-1:0]     stall_cycles
);
  if (DEPTH != 2) begin : g_depth_chk
    $error("if_id_buffer supports DEPTH == 2 only");
  end

  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             push, pop;
  ifid_entry_t      wdata, head;
  ifid_entry_t      entry_q [2];

  // Ready comes from registered count only: no dec_ready -> fetch_ready path.
  assign fetch_ready = (count_q != 2'd2) & ~reset;
  assign dec_valid   = (count_q != 2'd0);
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign pop         = dec_valid & dec_ready & ~flush;
  assign wdata       = '{pc: fetch_pc, instr: fetch_instr};

  for (genvar g = 0; g < 2; g++) begin : g_entry
    ifid_entry_reg u_entry (
      .clk   (clk),
      .reset (reset),
      .we_i  (push & (wr_ptr_q == 1'(g))),
      .d_i   (wdata),
      .q_o   (entry_q[g])
    );
  end

  // Empty buffer presents zeros so stale slots never leak to decode.
  assign head      = entry_q[rd_ptr_q];
  assign dec_pc    = dec_valid ? head.pc    : '0;
  assign dec_instr = dec_valid ? head.instr : '0;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (fetch_valid & ~fetch_ready & ~flush & (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_if_id_buffer.sv
`timescale 1ns/100ps
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 fetch_valid = 1'b0;
  logic [WORD-1:0]      fetch_pc = '0;
  logic [INSTR_LEN-1:0] fetch_instr = '0;
  logic                 fetch_ready;
  logic                 flush = 1'b0;
  logic                 dec_valid;
  logic [WORD-1:0]      dec_pc;
  logic [INSTR_LEN-1:0] dec_instr;
  logic                 dec_ready = 1'b0;
  logic [CW-1:0]        stall_cycles;

  if_id_buffer #(.DEPTH(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .flush(flush),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_ready(dec_ready), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of accepted, not-yet-consumed entries.
  ifid_entry_t sb[$];
  int          exp_stall = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, compares head/flags, consumes on pop.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("dec_valid", 64'(dec_valid), 64'(sb.size() != 0));
      chk("fetch_ready", 64'(fetch_ready), 64'((sb.size() != 2) && !reset));
      chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
      if (sb.size() != 0) begin
        chk("dec_pc", 64'(dec_pc), 64'(sb[0].pc));
        chk("dec_instr", 64'(dec_instr), 64'(sb[0].instr));
        if (dec_ready && !flush) void'(sb.pop_front());
      end else begin
        chk("dec_pc_zero", 64'(dec_pc), 64'd0);
        chk("dec_instr_zero", 64'(dec_instr), 64'd0);
      end
    end
  end

  // One cycle of stimulus; model update lands after the monitor, before the edge.
  task automatic cyc(input logic rst, input logic fv, input logic [31:0] pc,
                     input logic [31:0] ins, input logic fl, input logic dr);
    logic rdy, push, stl;
    @(negedge clk);
    reset = rst; fetch_valid = fv; fetch_pc = pc; fetch_instr = ins;
    flush = fl; dec_ready = dr;
    rdy  = (sb.size() != 2) && !rst;
    push = fv && rdy && !fl;
    stl  = fv && !rdy && !fl && !rst;
    #3;
    if (rst) begin
      sb.delete();
      exp_stall = 0;
    end else begin
      if (fl) sb.delete();
      else if (push) sb.push_back('{pc: pc, instr: ins});
      if (stl && exp_stall != SMAX) exp_stall++;
    end
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, $urandom, $urandom, 1'b0, dr);
  endtask

  initial begin
    // Reset held, then released
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Single pass
    cyc(1'b0, 1'b1, 32'h100, 32'h8B020020, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Streaming, one per cycle
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Backpressure fill: 0x8 refused while full, stall counted
    cyc(1'b0, 1'b1, 32'h0, 32'hA0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h4, 32'hA4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h8, 32'hA8, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 32'h8, 32'hA8, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Flush with full buffer and a same-cycle push
    cyc(1'b0, 1'b1, 32'h10, 32'hB0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h14, 32'hB4, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h20, 32'hC0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 32'h200, 32'hD0, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Async reset mid-stream with two entries buffered
    cyc(1'b0, 1'b1, 32'h30, 32'hE0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h34, 32'hE4, 1'b0, 1'b0);
    @(negedge clk);
    fetch_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0;
    #1 reset = 1'b1;
    #0.5;
    chk("async_dec_valid", 64'(dec_valid), 64'd0);
    chk("async_dec_pc", 64'(dec_pc), 64'd0);
    chk("async_dec_instr", 64'(dec_instr), 64'd0);
    chk("async_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("async_stall", 64'(stall_cycles), 64'd0);
    sb.delete();
    exp_stall = 0;
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b0, 1'b1, 32'h300, 32'hF00D, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Random traffic (small counter width also exercises saturation)
    for (int i = 0; i < 400; i++)
      cyc(1'b0, ($urandom_range(0, 9) < 7), $urandom, $urandom,
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 5));
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
